// File: rtl/fifo_gen2_pkg.sv
// Shared types, default geometry and occupancy arithmetic for the
// second-generation circular FIFO.
package fifo_gen2_pkg;

    // Default geometry. Instances with other widths derive their own local
    // types from their ADDR_WIDTH parameter using the same pattern.
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEPTH          = 2 ** DEF_ADDR_WIDTH;

    typedef logic [DEF_ADDR_WIDTH-1:0] ptr_t;
    typedef logic [DEF_ADDR_WIDTH:0]   cnt_t;

    // Occupancy after one cycle: +1 on a lone write, -1 on a lone read,
    // unchanged when both or neither are accepted.
    function automatic int next_count(input int cur, input logic inc, input logic dec);
        int res;
        res = cur;
        if (inc && !dec) begin
            res = cur + 1;
        end else if (dec && !inc) begin
            res = cur - 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_storage.sv
// Register-array storage: one synchronous write port, one asynchronous
// read port. No reset; contents are only meaningful where the controller
// says they are.
module fifo_storage #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] r_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Write port: store the word on an enabled clock edge.
    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end

    assign r_data = mem[r_addr];

endmodule

// File: rtl/circ_fifo_gen2.sv
// Circular FIFO controller with occupancy count, programmable almost-full /
// almost-empty thresholds, synchronous flush, FWFT or registered read, and
// overflow/underflow pulses. Single clock domain.
module circ_fifo_gen2 #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    import fifo_gen2_pkg::*;

    localparam int FIFO_DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W      = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_d;
    logic                  rd_acc;
    logic                  wr_acc;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Acceptance from registered state; a write into a full FIFO only goes
    // through when a read frees a slot in the same cycle. Flush forces the
    // next occupancy to zero so the flags fall back to their reset values.
    always_comb begin
        rd_acc = rd & ~empty;
        wr_acc = wr & (~full | rd_acc);
        cnt_d  = CNT_W'(next_count(int'(cnt), wr_acc, rd_acc));
        if (clear) begin
            cnt_d = '0;
        end
    end

    fifo_storage #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_storage (
        .clk    (clk),
        .w_en   (wr_acc & ~clear),
        .w_addr (wptr),
        .w_data (write_data),
        .r_addr (rptr),
        .r_data (mem_rdata)
    );

    // Pointers wrap by natural overflow of the ADDR_WIDTH-bit counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_acc) wptr <= wptr + 1'b1;
            if (rd_acc) rptr <= rptr + 1'b1;
        end
    end

    // Occupancy and status flags, all registered from the next count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
        end else begin
            cnt          <= cnt_d;
            empty        <= (cnt_d == '0);
            full         <= (cnt_d == CNT_W'(FIFO_DEPTH));
            almost_empty <= (cnt_d <= CNT_W'(AE_LEVEL));
            almost_full  <= (cnt_d >= CNT_W'(AF_LEVEL));
        end
    end

    // Rejected requests pulse for one cycle; a flush swallows that cycle's requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ~clear & wr & ~wr_acc;
            underflow <= ~clear & rd & empty;
        end
    end

    assign count = cnt;

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented straight from storage; masked while empty
            // so a freshly reset FIFO shows zero rather than stale contents.
            assign read_data = empty ? '0 : mem_rdata;
            assign rd_valid  = ~empty;
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] rdata_q;
            logic                  rvld_q;

            // Registered read: popped word appears one cycle after the accepted read.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rdata_q <= '0;
                    rvld_q  <= 1'b0;
                end else begin
                    rvld_q <= rd_acc & ~clear;
                    if (rd_acc && !clear) begin
                        rdata_q <= mem_rdata;
                    end
                end
            end

            assign read_data = rdata_q;
            assign rd_valid  = rvld_q;
        end
    endgenerate

endmodule

// File: tb/tb_circ_fifo_gen2.sv
module tb_circ_fifo_gen2;

    logic clk;
    logic reset;

    // Registered-read instance (FWFT=0)
    logic       clear, wr, rd;
    logic [7:0] write_data, read_data;
    logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    // FWFT instance
    logic       f_clear, f_wr, f_rd;
    logic [7:0] f_write_data, f_read_data;
    logic       f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [3:0] f_count;

    int total = 0;
    int bad   = 0;

    circ_fifo_gen2 #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) dut (
        .clk(clk), .reset(reset), .clear(clear), .wr(wr), .write_data(write_data), .rd(rd),
        .read_data(read_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    circ_fifo_gen2 #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) dut_f (
        .clk(clk), .reset(reset), .clear(f_clear), .wr(f_wr), .write_data(f_write_data), .rd(f_rd),
        .read_data(f_read_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       wr;
        logic       rd;
        logic [7:0] wd;
        logic [7:0] cnt;
        logic [7:0] e;
        logic [7:0] f;
        logic [7:0] ae;
        logic [7:0] af;
        logic [7:0] rdv;
        logic [7:0] rdata;
        logic [7:0] ovf;
        logic [7:0] udf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic c, input logic w, input logic r, input logic [7:0] wd,
                       input logic [7:0] cn, input logic [7:0] e, input logic [7:0] f,
                       input logic [7:0] ae, input logic [7:0] af, input logic [7:0] rdv,
                       input logic [7:0] rdat, input logic [7:0] ovf, input logic [7:0] udf);
        vec_t v;
        v.clr = c; v.wr = w; v.rd = r; v.wd = wd;
        v.cnt = cn; v.e = e; v.f = f; v.ae = ae; v.af = af;
        v.rdv = rdv; v.rdata = rdat; v.ovf = ovf; v.udf = udf;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        clear = 0; wr = 0; rd = 0; write_data = 8'h00;
        f_clear = 0; f_wr = 0; f_rd = 0; f_write_data = 8'h00;

        //  clr wr rd wd      cnt e  f  ae af rdv rdata ovf udf
        add(0, 1, 0, 8'hA1,  1, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        add(0, 1, 0, 8'hB2,  2, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        add(0, 1, 0, 8'hC3,  3, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        add(0, 0, 1, 8'h00,  2, 0, 0, 1, 0, 1, 8'hA1, 0, 0);
        add(0, 0, 1, 8'h00,  1, 0, 0, 1, 0, 1, 8'hB2, 0, 0);
        add(0, 0, 1, 8'h00,  0, 1, 0, 1, 0, 1, 8'hC3, 0, 0);
        add(0, 0, 0, 8'h00,  0, 1, 0, 1, 0, 0, 8'hC3, 0, 0);
        // fill 0x00..0x08 starting at pointer 3 (wraps)
        add(0, 1, 0, 8'h00,  1, 0, 0, 1, 0, 0, 8'hC3, 0, 0);
        add(0, 1, 0, 8'h01,  2, 0, 0, 1, 0, 0, 8'hC3, 0, 0);
        add(0, 1, 0, 8'h02,  3, 0, 0, 0, 0, 0, 8'hC3, 0, 0);
        add(0, 1, 0, 8'h03,  4, 0, 0, 0, 0, 0, 8'hC3, 0, 0);
        add(0, 1, 0, 8'h04,  5, 0, 0, 0, 0, 0, 8'hC3, 0, 0);
        add(0, 1, 0, 8'h05,  6, 0, 0, 0, 1, 0, 8'hC3, 0, 0);
        add(0, 1, 0, 8'h06,  7, 0, 0, 0, 1, 0, 8'hC3, 0, 0);
        add(0, 1, 0, 8'h07,  8, 0, 1, 0, 1, 0, 8'hC3, 0, 0);
        add(0, 1, 0, 8'h08,  8, 0, 1, 0, 1, 0, 8'hC3, 1, 0);
        add(0, 0, 0, 8'h00,  8, 0, 1, 0, 1, 0, 8'hC3, 0, 0);
        // write+read while full
        add(0, 1, 1, 8'h99,  8, 0, 1, 0, 1, 1, 8'h00, 0, 0);
        // drain
        add(0, 0, 1, 8'h00,  7, 0, 0, 0, 1, 1, 8'h01, 0, 0);
        add(0, 0, 1, 8'h00,  6, 0, 0, 0, 1, 1, 8'h02, 0, 0);
        add(0, 0, 1, 8'h00,  5, 0, 0, 0, 0, 1, 8'h03, 0, 0);
        add(0, 0, 1, 8'h00,  4, 0, 0, 0, 0, 1, 8'h04, 0, 0);
        add(0, 0, 1, 8'h00,  3, 0, 0, 0, 0, 1, 8'h05, 0, 0);
        add(0, 0, 1, 8'h00,  2, 0, 0, 1, 0, 1, 8'h06, 0, 0);
        add(0, 0, 1, 8'h00,  1, 0, 0, 1, 0, 1, 8'h07, 0, 0);
        add(0, 0, 1, 8'h00,  0, 1, 0, 1, 0, 1, 8'h99, 0, 0);
        add(0, 0, 1, 8'h00,  0, 1, 0, 1, 0, 0, 8'h99, 0, 1);
        // write+read while empty
        add(0, 1, 1, 8'h3C,  1, 0, 0, 1, 0, 0, 8'h99, 0, 1);
        add(0, 0, 1, 8'h00,  0, 1, 0, 1, 0, 1, 8'h3C, 0, 0);
        // five words then flush with a write
        add(0, 1, 0, 8'h11,  1, 0, 0, 1, 0, 0, 8'h3C, 0, 0);
        add(0, 1, 0, 8'h12,  2, 0, 0, 1, 0, 0, 8'h3C, 0, 0);
        add(0, 1, 0, 8'h13,  3, 0, 0, 0, 0, 0, 8'h3C, 0, 0);
        add(0, 1, 0, 8'h14,  4, 0, 0, 0, 0, 0, 8'h3C, 0, 0);
        add(0, 1, 0, 8'h15,  5, 0, 0, 0, 0, 0, 8'h3C, 0, 0);
        add(1, 1, 0, 8'h77,  0, 1, 0, 1, 0, 0, 8'h3C, 0, 0);
        // fill, then flush with write+read while full
        add(0, 1, 0, 8'h20,  1, 0, 0, 1, 0, 0, 8'h3C, 0, 0);
        add(0, 1, 0, 8'h21,  2, 0, 0, 1, 0, 0, 8'h3C, 0, 0);
        add(0, 1, 0, 8'h22,  3, 0, 0, 0, 0, 0, 8'h3C, 0, 0);
        add(0, 1, 0, 8'h23,  4, 0, 0, 0, 0, 0, 8'h3C, 0, 0);
        add(0, 1, 0, 8'h24,  5, 0, 0, 0, 0, 0, 8'h3C, 0, 0);
        add(0, 1, 0, 8'h25,  6, 0, 0, 0, 1, 0, 8'h3C, 0, 0);
        add(0, 1, 0, 8'h26,  7, 0, 0, 0, 1, 0, 8'h3C, 0, 0);
        add(0, 1, 0, 8'h27,  8, 0, 1, 0, 1, 0, 8'h3C, 0, 0);
        add(1, 1, 1, 8'h88,  0, 1, 0, 1, 0, 0, 8'h3C, 0, 0);
        add(0, 1, 0, 8'h42,  1, 0, 0, 1, 0, 0, 8'h3C, 0, 0);
        add(0, 0, 1, 8'h00,  0, 1, 0, 1, 0, 1, 8'h42, 0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // reset state
        check("rst_count", 8'(count), 8'h00);
        check("rst_empty", 8'(empty), 8'h01);
        check("rst_full", 8'(full), 8'h00);
        check("rst_ae", 8'(almost_empty), 8'h01);
        check("rst_af", 8'(almost_full), 8'h00);
        check("rst_rdata", read_data, 8'h00);
        check("rst_rdv", 8'(rd_valid), 8'h00);
        check("rst_ovf", 8'(overflow), 8'h00);
        check("rst_udf", 8'(underflow), 8'h00);
        check("rst_f_rdv", 8'(f_rd_valid), 8'h00);

        // table-driven sequence on the registered-read instance
        for (int i = 0; i < vecs.size(); i++) begin
            clear = vecs[i].clr; wr = vecs[i].wr; rd = vecs[i].rd; write_data = vecs[i].wd;
            cycle();
            check($sformatf("v%0d_count", i), 8'(count), vecs[i].cnt);
            check($sformatf("v%0d_empty", i), 8'(empty), vecs[i].e);
            check($sformatf("v%0d_full", i), 8'(full), vecs[i].f);
            check($sformatf("v%0d_ae", i), 8'(almost_empty), vecs[i].ae);
            check($sformatf("v%0d_af", i), 8'(almost_full), vecs[i].af);
            check($sformatf("v%0d_rdv", i), 8'(rd_valid), vecs[i].rdv);
            check($sformatf("v%0d_rdata", i), read_data, vecs[i].rdata);
            check($sformatf("v%0d_ovf", i), 8'(overflow), vecs[i].ovf);
            check($sformatf("v%0d_udf", i), 8'(underflow), vecs[i].udf);
        end
        clear = 0; wr = 0; rd = 0; write_data = 8'h00;

        // FWFT: word visible the cycle after writing into an empty FIFO
        f_wr = 1; f_write_data = 8'h5A;
        cycle();
        f_wr = 0;
        check("fwft_rdata", f_read_data, 8'h5A);
        check("fwft_rdv", 8'(f_rd_valid), 8'h01);
        cycle();
        check("fwft_hold", f_read_data, 8'h5A);
        f_rd = 1;
        cycle();
        f_rd = 0;
        check("fwft_pop_empty", 8'(f_empty), 8'h01);
        check("fwft_pop_rdv", 8'(f_rd_valid), 8'h00);
        f_wr = 1; f_write_data = 8'h6B;
        cycle();
        f_write_data = 8'h7C;
        cycle();
        f_wr = 0;
        check("fwft_head", f_read_data, 8'h6B);
        check("fwft_count2", 8'(f_count), 8'h02);
        f_rd = 1;
        cycle();
        f_rd = 0;
        check("fwft_next", f_read_data, 8'h7C);
        check("fwft_next_rdv", 8'(f_rd_valid), 8'h01);

        // async reset mid-burst, with a read result in flight
        wr = 1; write_data = 8'h55;
        cycle();
        write_data = 8'h66;
        cycle();
        wr = 1; rd = 1; write_data = 8'h67;
        cycle();
        check("pre_rst_rdata", read_data, 8'h55);
        check("pre_rst_rdv", 8'(rd_valid), 8'h01);
        #2;
        reset = 1'b1;
        #1;
        check("arst_count", 8'(count), 8'h00);
        check("arst_empty", 8'(empty), 8'h01);
        check("arst_full", 8'(full), 8'h00);
        check("arst_ae", 8'(almost_empty), 8'h01);
        check("arst_af", 8'(almost_full), 8'h00);
        check("arst_rdata", read_data, 8'h00);
        check("arst_rdv", 8'(rd_valid), 8'h00);
        check("arst_f_empty", 8'(f_empty), 8'h01);
        check("arst_f_rdata", f_read_data, 8'h00);
        wr = 0; rd = 0;
        cycle();
        @(negedge clk);
        reset = 1'b0;
        cycle();
        check("post_rst_count", 8'(count), 8'h00);
        check("post_rst_rdv", 8'(rd_valid), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/circ_fifo_gen2.md
Name: circ_fifo_gen2

Overview:
Parametrised second-generation circular FIFO for the datapath. Adds the following over the basic full/empty controller:
- occupancy count
- programmable almost-full/almost-empty thresholds
- synchronous flush
- selectable first-word-fall-through (FWFT) or registered-read mode
- overflow/underflow error pulses

It sits between producer and consumer blocks in one clock domain and drives a dedicated storage sub-module.

Parameters:
ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH entries (legal 1..10)
DATA_WIDTH, 8, word width in bits
AF_LEVEL, 6, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = registered read (1-cycle latency), 1 = head word visible on read_data while !empty

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous flush; empties FIFO, storage contents don't care
wr  in  1  write request
write_data  in  DATA_WIDTH  write word
rd  in  1  read request (FWFT=1: pop/acknowledge head)
read_data  out  DATA_WIDTH  read word
rd_valid  out  1  FWFT=0: pulses the cycle read_data carries a popped word; FWFT=1: equals !empty
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  out  1  1-cycle pulse: write rejected
underflow  out  1  1-cycle pulse: read rejected

Behaviour:
- Reset (async assert, sync release):
  - wptr = rptr = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0
  - read_data = 0, rd_valid = 0, overflow = underflow = 0
- Acceptance, evaluated on registered state each cycle:
  - rd_acc = rd & !empty
  - wr_acc = wr & (!full | rd_acc). A write when full is accepted only with a simultaneous accepted read.
- Error pulses:
  - overflow = wr & !wr_acc, registered, asserted the next cycle for 1 cycle
  - underflow = rd & empty, same timing
- Pointers: wr_acc stores write_data at wptr and increments wptr; rd_acc increments rptr. Both wrap DEPTH-1 -> 0 by natural modulo-2**ADDR_WIDTH overflow.
- count update: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither. Flags are registered and derived from the next count, so they are valid the cycle after the update.
- Empty-with-wr&rd: read rejected (underflow pulse), write accepted, count 0 -> 1. No bypass path.
- FWFT=0:
  - on rd_acc, read_data <= mem[rptr] and rd_valid = 1 next cycle (1-cycle latency)
  - read_data holds its value otherwise; rd_valid = 0 otherwise
- FWFT=1:
  - read_data = mem[rptr], combinational from async-read storage
  - written word becomes visible the cycle after the write to an empty FIFO
  - rd_acc advances to the next word
- clear: takes priority over wr/rd in the same cycle.
  - next cycle: pointers 0, count 0, flags at reset values
  - overflow/underflow not raised for that cycle's requests
  - read_data not changed in FWFT=0
- Reset mid-operation: immediate async return to reset values; any in-flight read result is discarded.
- Threshold flags are independent of full/empty; with AF_LEVEL = DEPTH, almost_full equals full.

Decomposition:
- Package fifo_gen2_pkg:
  - typedef ptr_t = logic [ADDR_WIDTH-1:0]
  - typedef cnt_t = logic [ADDR_WIDTH:0]
  - localparam DEPTH
  - function for next-count calculation
  Parametrised types are declared via the package's parameterised-class or localparam pattern.
- Sub-module fifo_storage: register array with one synchronous write port (w_en, w_addr, w_data) and one asynchronous read port (r_addr, r_data).
- Top module holds pointers, count, flags, error pulses and the FWFT output mux/register.

Test Plan:
- Reset, FWFT=0: after reset release, empty=1, almost_empty=1, count=0, read_data=0. Then write 0xA1, 0xB2, 0xC3 and issue 3 reads -> read_data 0xA1, 0xB2, 0xC3, each 1 cycle after its rd, with rd_valid pulsing; count 3 -> 0.
- Fill/overflow, DEPTH=8: write 9 words 0x00..0x08 -> full=1 after the 8th write; 9th write raises overflow for 1 cycle; count stays 8; draining yields 0x00..0x07 (wrap verified).
- Thresholds, AF_LEVEL=6, AE_LEVEL=2:
  - writing: almost_empty drops when count reaches 3; almost_full rises when count reaches 6
  - reading back down: almost_full falls when count reaches 5; almost_empty rises when count reaches 2
- Simultaneous rd&wr:
  - when full: both accepted, count stays 8, no overflow
  - when empty: write accepted, underflow pulses, count = 1
- FWFT=1: write 0x5A to empty FIFO -> next cycle read_data=0x5A and rd_valid=1 with no rd issued; rd -> empty=1 the next cycle.
- clear and async reset:
  - with count=5, assert clear together with wr=1 -> next cycle count=0, empty=1, no overflow
  - assert reset mid-burst, asynchronously between clock edges -> outputs return to reset values immediately
